// File: rtl/paralelo_serial_if.sv
// -----------------------------------------------------------------------------
// paralelo_serial_if
// Bus between the word-rate encoder stage and the parallel-to-serial
// transmitter.
//   enb      : clock enable; 0 freezes the transmitter
//   clk10    : divide-by-10 word clock from clks, sampled as data
//   entradas : WIDTH-bit parallel word to transmit
//   salida   : registered serial output, MSB first
// Modports:
//   master : the side feeding words and consuming the serial bit
//   slave  : the transmitter itself
// -----------------------------------------------------------------------------
interface paralelo_serial_if #(
  parameter int WIDTH = 10
);
  logic             enb;
  logic             clk10;
  logic [WIDTH-1:0] entradas;
  logic             salida;

  modport master (
    output enb,
    output clk10,
    output entradas,
    input  salida
  );

  modport slave (
    input  enb,
    input  clk10,
    input  entradas,
    output salida
  );
endinterface

// File: rtl/paralelo_serial.sv
// -----------------------------------------------------------------------------
// paralelo_serial
// Parallel-to-serial transmitter. Captures a WIDTH-bit word once per word
// period and shifts it out one bit per clk cycle on salida, MSB first, with
// words sent back-to-back.
//
// Ports:
//   clk : bit clock, all state on its rising edge
//   rst : synchronous active-low reset (priority over enb)
//   bus : paralelo_serial_if.slave (enb, clk10, entradas, salida)
//
// Configuration:
//   PARALELO_SERIAL_CLK10_SYNC_EN - when defined, a rising edge of clk10
//   (seen at an enabled clk edge) forces an immediate load, so the word
//   boundary tracks the clks divider phase. When undefined, clk10 is ignored
//   and the bit counter free-runs.
// -----------------------------------------------------------------------------
module paralelo_serial #(
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  paralelo_serial_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    contador, contador_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             salida_d;
  logic             load;

`ifdef PARALELO_SERIAL_CLK10_SYNC_EN
  logic clk10_q;

  // A realign (clk10 rising) abandons the word in flight. When it coincides
  // with the natural wrap it is still a single load.
  assign load = (contador == LAST) || (bus.clk10 && !clk10_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk10_q <= 1'b0;
    end else if (bus.enb) begin
      clk10_q <= bus.clk10;
    end
  end
`else
  // clk10 is not part of the datapath in this build.
  logic unused_clk10;
  assign unused_clk10 = bus.clk10;

  assign load = (contador == LAST);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    contador_d = contador;
    shreg_d    = shreg;
    salida_d   = bus.salida;
    if (load) begin
      // Bit WIDTH-1 goes straight to the output; the rest wait in shreg.
      salida_d   = bus.entradas[WIDTH-1];
      shreg_d    = {bus.entradas[WIDTH-2:0], 1'b0};
      contador_d = '0;
    end else begin
      salida_d   = shreg[WIDTH-1];
      shreg_d    = shreg << 1;
      contador_d = contador + 1'b1;
    end
  end

  // Reset value of contador is the last index, so the first enabled edge
  // after reset release is a load edge.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      contador   <= LAST;
      shreg      <= '0;
      bus.salida <= 1'b0;
    end else if (bus.enb) begin
      contador   <= contador_d;
      shreg      <= shreg_d;
      bus.salida <= salida_d;
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial
// Self-checking bench for paralelo_serial. A behavioural model keeps the word
// in flight and the index of the bit on the line; the expected output is the
// word bit selected by that index.
// -----------------------------------------------------------------------------
module tb_paralelo_serial;

  localparam int WIDTH = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  paralelo_serial_if #(.WIDTH(WIDTH)) bus ();

  paralelo_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the word being sent and which bit position is on the line.
  logic [WIDTH-1:0] m_word = '0;
  int               m_idx  = WIDTH - 1;
  logic             m_out  = 1'b0;
  logic             m_clk10_q = 1'b0;

  // Advance one clock edge and update the model from the inputs held across it.
  task automatic step();
    bit realign;
    @(posedge clk);
    if (!rst) begin
      m_word    = '0;
      m_idx     = WIDTH - 1;
      m_out     = 1'b0;
      m_clk10_q = 1'b0;
    end else if (bus.enb) begin
`ifdef PARALELO_SERIAL_CLK10_SYNC_EN
      realign   = bus.clk10 && !m_clk10_q;
      m_clk10_q = bus.clk10;
`else
      realign   = 1'b0;
`endif
      if (m_idx == WIDTH - 1 || realign) begin
        m_word = bus.entradas;
        m_idx  = 0;
      end else begin
        m_idx = m_idx + 1;
      end
      m_out = m_word[WIDTH-1-m_idx];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.enb = 1'b1;
    bus.clk10 = 1'b0;
    bus.entradas = 10'b1010010101;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.salida !== 1'b0) begin
        bad++;
        $display("FAIL reset_salida[%0d]: got %b expected 0", i, bus.salida);
      end
      total++;
      if (dut.contador !== 4'd9) begin
        bad++;
        $display("FAIL reset_contador[%0d]: got %0d expected 9", i, dut.contador);
      end
    end
  endtask

  task automatic test_first_word();
    logic [WIDTH-1:0] w;
    w = 10'b1101101100;
    bus.entradas = w;
    bus.enb = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step();
      total++;
      if (bus.salida !== w[WIDTH-1-i] || bus.salida !== m_out) begin
        bad++;
        $display("FAIL first_word_bit[%0d]: got %b expected %b", i, bus.salida, w[WIDTH-1-i]);
      end
      total++;
      if (dut.contador !== 4'(i)) begin
        bad++;
        $display("FAIL first_word_contador[%0d]: got %0d expected %0d", i, dut.contador, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] stream;
    a = 10'b1111100000;
    b = 10'b0000011111;
    stream = {a, b};
    bus.entradas = a;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      step();
      // Switch to the next word mid-way through the first one.
      if (i == 4) bus.entradas = b;
      total++;
      if (bus.salida !== stream[2*WIDTH-1-i] || bus.salida !== m_out) begin
        bad++;
        $display("FAIL back_to_back_bit[%0d]: got %b expected %b", i, bus.salida, stream[2*WIDTH-1-i]);
      end
    end
  endtask

  task automatic test_enable();
    bus.entradas = 10'b1000000000;
    for (int i = 0; i < 5; i++) step();  // load + 4 shifts -> index 4
    bus.enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.salida !== 1'b0 || dut.contador !== 4'd4) begin
        bad++;
        $display("FAIL enable_hold[%0d]: got salida=%b contador=%0d expected salida=0 contador=4",
                 i, bus.salida, dut.contador);
      end
    end
    bus.enb = 1'b1;
    for (int i = 5; i < WIDTH; i++) begin
      step();
      total++;
      if (bus.salida !== 1'b0 || dut.contador !== 4'(i) || bus.salida !== m_out) begin
        bad++;
        $display("FAIL enable_resume[%0d]: got salida=%b contador=%0d expected salida=0 contador=%0d",
                 i, bus.salida, dut.contador, i);
      end
    end
  endtask

  task automatic test_realign();
    logic [WIDTH-1:0] w1, w2;
    logic [3:0] exp_cnt;
    logic exp_bit;
    w1 = WIDTH'($urandom);
    w2 = ~w1;
    bus.entradas = w1;
    for (int i = 0; i < 4; i++) step();  // index 3
    bus.clk10 = 1'b1;
    bus.entradas = w2;
`ifdef PARALELO_SERIAL_CLK10_SYNC_EN
    exp_cnt = 4'd0;
    exp_bit = w2[WIDTH-1];
`else
    exp_cnt = 4'd4;
    exp_bit = w1[WIDTH-1-4];
`endif
    step();
    total++;
    if (dut.contador !== exp_cnt || bus.salida !== exp_bit) begin
      bad++;
      $display("FAIL realign_edge: got salida=%b contador=%0d expected salida=%b contador=%0d",
               bus.salida, dut.contador, exp_bit, exp_cnt);
    end
    bus.clk10 = 1'b0;
    for (int n = 0; n < 2 * WIDTH && m_idx != WIDTH - 1; n++) begin
      step();
      total++;
      if (bus.salida !== m_out || dut.contador !== 4'(m_idx)) begin
        bad++;
        $display("FAIL realign_tail: got salida=%b contador=%0d expected salida=%b contador=%0d",
                 bus.salida, dut.contador, m_out, m_idx);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [WIDTH-1:0] w;
    bus.entradas = WIDTH'($urandom);
    for (int i = 0; i < 7; i++) step();  // index 6
    rst = 1'b0;
    step();
    total++;
    if (bus.salida !== 1'b0 || dut.contador !== 4'd9) begin
      bad++;
      $display("FAIL reset_midword: got salida=%b contador=%0d expected salida=0 contador=9",
               bus.salida, dut.contador);
    end
    rst = 1'b1;
    w = 10'b1011001110;
    bus.entradas = w;
    step();
    total++;
    if (bus.salida !== w[WIDTH-1] || dut.contador !== 4'd0) begin
      bad++;
      $display("FAIL reset_fresh_word: got salida=%b contador=%0d expected salida=%b contador=0",
               bus.salida, dut.contador, w[WIDTH-1]);
    end
    for (int i = 1; i < WIDTH; i++) begin
      step();
      total++;
      if (bus.salida !== w[WIDTH-1-i]) begin
        bad++;
        $display("FAIL reset_fresh_bit[%0d]: got %b expected %b", i, bus.salida, w[WIDTH-1-i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.enb      = ($urandom_range(0, 9) != 0);
      rst          = ($urandom_range(0, 59) != 0);
      bus.clk10    = ($urandom_range(0, 3) == 0);
      bus.entradas = WIDTH'($urandom);
      step();
      total++;
      if (bus.salida !== m_out || dut.contador !== 4'(m_idx)) begin
        bad++;
        $display("FAIL random[%0d]: got salida=%b contador=%0d expected salida=%b contador=%0d",
                 i, bus.salida, dut.contador, m_out, m_idx);
      end
    end
    rst = 1'b1;
    bus.enb = 1'b1;
    bus.clk10 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_enable();
    test_realign();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
